// File: rtl/memcheck.sv
// Read-only checker that walks a byte region through the memory controller and
// compares each byte with an expected fill value, reporting mismatches.
module memcheck #(
    parameter int MEMORY_CONTROLLER_ADDR_SIZE = 32,
    parameter int MEMORY_CONTROLLER_DATA_SIZE = 32,
    parameter int MAX_BYTES                   = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [MEMORY_CONTROLLER_ADDR_SIZE-1:0] m,
    input  logic [MEMORY_CONTROLLER_DATA_SIZE-1:0] c,
    input  logic [MEMORY_CONTROLLER_DATA_SIZE-1:0] n,
    output logic                                   finish,
    output logic                                   pass,
    output logic [5:0]                             mismatch_count,
    output logic [MEMORY_CONTROLLER_ADDR_SIZE-1:0] first_bad_addr,
    output logic [MEMORY_CONTROLLER_ADDR_SIZE-1:0] memory_controller_address,
    output logic                                   memory_controller_write_enable,
    output logic [MEMORY_CONTROLLER_DATA_SIZE-1:0] memory_controller_in,
    input  logic [MEMORY_CONTROLLER_DATA_SIZE-1:0] memory_controller_out
);

    localparam int AW = MEMORY_CONTROLLER_ADDR_SIZE;
    localparam int DW = MEMORY_CONTROLLER_DATA_SIZE;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [5:0] MAXB = 6'(MAX_BYTES);

    logic [2:0]    r_state;
    logic [AW-1:0] r_m;
    logic [7:0]    r_c;
    logic [5:0]    r_cnt;
    logic [5:0]    r_idx;
    logic [5:0]    r_mis;
    logic [AW-1:0] r_fba;
    logic          r_pass;
    logic          r_finish;

    logic [5:0]    w_eff;
    logic [5:0]    w_idx_nxt;
    logic [AW-1:0] w_addr;
    logic          w_bad;
    logic          w_active;
    logic          w_unused;

    // Counts at or above MAX_BYTES clamp to MAX_BYTES; below that n fits in 6 bits.
    assign w_eff     = (n >= DW'(MAX_BYTES)) ? MAXB : n[5:0];
    assign w_idx_nxt = r_idx + 6'd1;
    assign w_addr    = r_m + {{(AW-6){1'b0}}, r_idx};
    assign w_bad     = (memory_controller_out[7:0] != r_c);
    assign w_active  = (r_state == S_ISSUE) || (r_state == S_READ);
    assign w_unused  = ^{c[DW-1:8], memory_controller_out[DW-1:8]};

    assign memory_controller_address      = w_active ? w_addr : '0;
    assign memory_controller_write_enable = 1'b0;
    assign memory_controller_in           = '0;

    assign finish         = r_finish;
    assign pass           = r_pass;
    assign mismatch_count = r_mis;
    assign first_bad_addr = r_fba;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_m      <= '0;
            r_c      <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_mis    <= '0;
            r_fba    <= '0;
            r_pass   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_m     <= m;
                    r_c     <= c[7:0];
                    r_cnt   <= w_eff;
                    r_idx   <= '0;
                    r_mis   <= '0;
                    r_fba   <= '0;
                    r_pass  <= 1'b0;
                    r_state <= (w_eff == 6'd0) ? S_DONE : S_ISSUE;
                end
                S_ISSUE: begin
                    r_state <= S_READ;
                end
                S_READ: begin
                    // Read data for the address issued last cycle is valid now.
                    if (w_bad) begin
                        r_mis <= r_mis + 6'd1;
                        if (r_mis == 6'd0) r_fba <= w_addr;
                    end
                    r_idx   <= w_idx_nxt;
                    r_state <= (w_idx_nxt == r_cnt) ? S_DONE : S_ISSUE;
                end
                S_DONE: begin
                    r_finish <= 1'b1;
                    r_pass   <= (r_mis == 6'd0);
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memcheck.sv
// Bench for memcheck: a 32-byte RAM stub with one-cycle read latency and a
// region-scan reference model that predicts latency, address trace and results.
module tb_memcheck;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] m, c, n;
    logic        finish, pass;
    logic [5:0]  mismatch_count;
    logic [31:0] first_bad_addr;
    logic [31:0] mc_addr;
    logic        mc_we;
    logic [31:0] mc_in;
    logic [31:0] mc_out;

    logic [7:0]  ram [32];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    memcheck #(
        .MEMORY_CONTROLLER_ADDR_SIZE(32),
        .MEMORY_CONTROLLER_DATA_SIZE(32),
        .MAX_BYTES(32)
    ) dut (
        .clk                            (clk),
        .reset                          (reset),
        .start                          (start),
        .m                              (m),
        .c                              (c),
        .n                              (n),
        .finish                         (finish),
        .pass                           (pass),
        .mismatch_count                 (mismatch_count),
        .first_bad_addr                 (first_bad_addr),
        .memory_controller_address      (mc_addr),
        .memory_controller_write_enable (mc_we),
        .memory_controller_in           (mc_in),
        .memory_controller_out          (mc_out)
    );

    // Controller stub: 5-bit byte address, data one cycle after address.
    always @(posedge clk) mc_out <= {24'h0, ram[mc_addr[4:0]]};

    always @(negedge clk)
        assert (mc_we === 1'b0 && mc_in === 32'h0)
            else $error("write port active: we=%b in=%h", mc_we, mc_in);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 32; i++) ram[i] = v;
    endtask

    // Reference: scan min(n,32) bytes from mm, aliasing through the 5-bit RAM.
    task automatic run(input string tag, input logic [31:0] mm, input logic [31:0] cc,
                       input logic [31:0] nn);
        int k, fj, bad, emis;
        logic [31:0] efba, ea;
        k = (nn > 32) ? 32 : int'(nn);
        emis = 0;
        efba = 0;
        for (int i = 0; i < k; i++) begin
            ea = mm + i;
            if (ram[ea[4:0]] != cc[7:0]) begin
                if (emis == 0) efba = ea;
                emis++;
            end
        end
        @(negedge clk);
        m = mm; c = cc; n = nn; start = 1'b1;
        @(posedge clk);
        fj = -1;
        bad = 0;
        for (int j = 0; j < 200 && fj < 0; j++) begin
            @(negedge clk);
            if (j == 0) start = 1'b0;
            ea = (j >= 1 && j <= 2 * k) ? mm + (j - 1) / 2 : 32'h0;
            if (mc_addr !== ea) bad++;
            if (finish === 1'b1) fj = j;
        end
        chk({tag, ".latency"}, fj, 2 * k + 2);
        chk({tag, ".addr_trace"}, bad, 0);
        chk({tag, ".mis_cnt"}, {26'h0, mismatch_count}, emis);
        chk({tag, ".first_bad"}, first_bad_addr, efba);
        chk({tag, ".pass"}, {31'h0, pass}, (emis == 0) ? 1 : 0);
        @(negedge clk);
        chk({tag, ".finish_1cyc"}, {31'h0, finish}, 0);
    endtask

    initial begin
        int fq[$];
        int seen;
        logic [31:0] rm, rc, rn;
        int sel;

        reset = 1'b1; start = 1'b0; m = 0; c = 0; n = 0;
        fill(8'h00);
        repeat (3) @(negedge clk);
        chk("rst.finish", {31'h0, finish}, 0);
        chk("rst.pass", {31'h0, pass}, 0);
        chk("rst.mis", {26'h0, mismatch_count}, 0);
        chk("rst.fba", first_bad_addr, 0);
        chk("rst.addr", mc_addr, 0);
        reset = 1'b0;

        fill(8'hA5);
        run("clean8", 32'h0, 32'hA5, 32'd8);

        ram[3] = 8'h00; ram[6] = 8'h11;
        run("two_bad", 32'h0, 32'hA5, 32'd8);
        chk("two_bad.cnt_direct", {26'h0, mismatch_count}, 2);
        chk("two_bad.fba_direct", first_bad_addr, 3);

        fill(8'hA5);
        run("zero_n", 32'h5, 32'hA5, 32'd0);
        run("clamp100", 32'h7, 32'h3C, 32'd100);
        fill(8'h3C);
        run("clamp100_ok", 32'h7, 32'h3C, 32'd100);
        run("clamp_huge", 32'h0, 32'h3C, 32'hFFFF_FFFF);
        fill(8'hA5);
        run("c_upper", 32'h0, 32'hFFFF_FFA5, 32'd8);
        ram[0] = 8'h01;
        run("wrap", 32'hFFFF_FFFE, 32'hA5, 32'd4);

        // Abort during the READ of byte 4 after one mismatch has been recorded.
        fill(8'hA5);
        ram[1] = 8'h00;
        @(negedge clk);
        m = 0; c = 32'hA5; n = 8; start = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 10; j++) begin
            @(negedge clk);
            if (j == 0) start = 1'b0;
        end
        chk("abort.pre_mis", {26'h0, mismatch_count}, 1);
        reset = 1'b1;
        #1;
        chk("abort.finish", {31'h0, finish}, 0);
        chk("abort.mis", {26'h0, mismatch_count}, 0);
        chk("abort.fba", first_bad_addr, 0);
        chk("abort.addr", mc_addr, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (finish === 1'b1) seen++;
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (finish === 1'b1) seen++;
        end
        chk("abort.no_finish", seen, 0);
        fill(8'hA5);
        run("restart", 32'h0, 32'hA5, 32'd8);

        // start held high: ignored mid-run, re-triggers in the IDLE after DONE.
        @(negedge clk);
        m = 0; c = 32'hA5; n = 2; start = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 60 && fq.size() < 2; j++) begin
            @(negedge clk);
            if (finish === 1'b1) begin
                fq.push_back(j);
                if (fq.size() == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b.count", fq.size(), 2);
        if (fq.size() == 2) begin
            chk("b2b.first", fq[0], 6);
            chk("b2b.second", fq[1], 13);
        end
        repeat (10) @(negedge clk);

        for (int t = 0; t < 20; t++) begin
            rm = $urandom;
            rc = $urandom;
            sel = $urandom_range(0, 9);
            rn = (sel < 7) ? $urandom_range(0, 40) : ((sel < 9) ? 32'd100 : $urandom);
            for (int i = 0; i < 32; i++)
                ram[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : rc[7:0];
            run($sformatf("rnd%0d", t), rm, rc, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memcheck.md
MEMCHECK -- requirements
Module: memcheck

Interface
REQ-001 Parameter MEMORY_CONTROLLER_ADDR_SIZE, default 32, width of the memory-controller address bus.
REQ-002 Parameter MEMORY_CONTROLLER_DATA_SIZE, default 32, width of the memory-controller data buses.
REQ-003 Parameter MAX_BYTES, default 32, depth of the byte RAM behind the memory controller.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 start  input  1  level-sampled in IDLE; begins a check run.
REQ-007 m  input  32  base address of the region that memset filled.
REQ-008 c  input  32  expected fill value; only c[7:0] is compared.
REQ-009 n  input  32  byte count to check.
REQ-010 finish  output  1  one-cycle completion pulse.
REQ-011 pass  output  1  set to 1 when the run found zero mismatches.
REQ-012 mismatch_count  output  6  number of bytes that differ from c[7:0].
REQ-013 first_bad_addr  output  32  address of the first mismatching byte, or 0 if none.
REQ-014 memory_controller_address  output  32  read address.
REQ-015 memory_controller_write_enable  output  1  tied to 0 in every state; the block is read-only.
REQ-016 memory_controller_in  output  32  held at 0 in every state, so the controller always selects tag 0 (str).
REQ-017 memory_controller_out  input  32  read data; byte in bits [7:0], valid one cycle after its address.

Function
REQ-018 The FSM SHALL use these states: IDLE, SETUP, ISSUE, READ, DONE.
REQ-019 IDLE -> SETUP when start=1; otherwise IDLE SHALL hold and outputs SHALL keep their last values.
REQ-020 SETUP SHALL latch m, c[7:0] and the effective count.
- Effective count = min(n, MAX_BYTES).
- Index is cleared to 0, mismatch_count to 0, first_bad_addr to 0, pass to 0.
REQ-021 SETUP -> DONE if the effective count is 0; otherwise SETUP -> ISSUE.
REQ-022 ISSUE SHALL drive memory_controller_address = m_latched + index (32-bit add, wrap modulo 2^32), then go to READ.
REQ-023 READ SHALL hold the same address and compare memory_controller_out[7:0] against c_latched.
REQ-024 On a mismatch, mismatch_count SHALL increment.
- If this is the first mismatch, first_bad_addr SHALL capture the current address.
REQ-025 READ SHALL increment index.
- If the new index equals the effective count: READ -> DONE.
- Otherwise: READ -> ISSUE.
REQ-026 Each byte SHALL take exactly 2 cycles, so a k-byte run takes 2k+2 cycles from the start sample to finish.
REQ-027 DONE SHALL assert finish for exactly one cycle, set pass = (mismatch_count == 0), and return to IDLE.
REQ-028 start asserted outside IDLE SHALL be ignored.
- start still high in the IDLE cycle after DONE SHALL begin a new run.
REQ-029 The RAM address space is 5 bits, so addresses that differ only above bit 4 alias.
- The checker SHALL NOT special-case aliasing; it reads whatever the controller returns.
REQ-030 Internal counters SHALL be 6 bits so that a count of 32 neither overflows nor saturates.
REQ-031 memory_controller_address SHALL be 0 in IDLE, SETUP and DONE.

Reset
REQ-032 While reset=1, the FSM SHALL be in IDLE and finish, pass, mismatch_count, first_bad_addr and memory_controller_address SHALL be 0.
REQ-033 Reset asserted mid-run SHALL abort the run with no finish pulse.
- The first cycle after release is IDLE and honours start.
REQ-034 Write enable and memory_controller_in SHALL be 0 during and after reset.

Verification
REQ-035 RAM preloaded by memset with c=0xA5; start with m=0, n=8 -> finish 18 cycles after the start sample, pass=1, mismatch_count=0, first_bad_addr=0.
REQ-036 RAM bytes 0..7 = 0xA5 except byte 3 = 0x00 and byte 6 = 0x11; start with m=0, n=8, c=0xA5 -> pass=0, mismatch_count=2, first_bad_addr=3.
REQ-037 start with n=0 -> finish 2 cycles after the start sample, pass=1, no ISSUE state visited.
REQ-038 start with n=100 and all bytes = c -> exactly 32 reads (addresses m..m+31), finish after 66 cycles, mismatch_count=0.
REQ-039 Assert reset during READ of byte 4 of 8 -> outputs 0 immediately, no finish pulse; a restart with n=8 then completes normally.
REQ-040 Throughout every run, memory_controller_write_enable=0 and memory_controller_in=0 on every cycle (checked by assertion).
